axis_wrr_pkt_arbiter: RTL and testbench
=======================================

// Module: axis_wrr_pkt_arbiter
// PURPOSE
//  Packet-level weighted round-robin arbiter. It merges N_PORTS AXI-Stream slave inputs onto one master output.
//  A grant is held from the first beat of a packet until its tlast, so packets never interleave.
//  Each grant carries a per-port packet budget (cfg_weight), which shares the downstream stream bandwidth between requesters.
//  It sits in front of the shared m0k-style output stream and replaces fixed two-input muxing with a scalable scheduler.
// PARAMETERS
//  N_PORTS   2   number of slave input streams (>=2)
//  DATA_W    32  tdata width in bits
//  WEIGHT_W  4   width of each per-port weight field
// PORTS
//  axis_aclk      in   1                clock; all logic on rising edge
//  axis_areset    in   1                synchronous, active-high reset
//  s_axis_tdata   in   N_PORTS*DATA_W   slave data; port i occupies [i*DATA_W +: DATA_W]
//  s_axis_tvalid  in   N_PORTS          slave valid, one bit per port
//  s_axis_tready  out  N_PORTS          slave ready, one bit per port
//  s_axis_tlast   in   N_PORTS          slave end-of-packet, one bit per port
//  m_axis_tdata   out  DATA_W           master data
//  m_axis_tvalid  out  1                master valid
//  m_axis_tready  in   1                master ready
//  m_axis_tlast   out  1                master end-of-packet
//  m_axis_tid     out  $clog2(N_PORTS)  index of the granted source port
//  cfg_weight     in   N_PORTS*WEIGHT_W packets per grant turn; a weight of 0 is treated as 1
//  busy           out  1                high while in XFER
// BEHAVIOUR
//  Reset values: state=ARB, grant=0, rr pointer=0 (port 0 highest priority), credit=0.
//   All s_axis_tready=0, m_axis_tvalid=0, m_axis_tid=0, busy=0.
//  Reset asserted mid-packet: the packet is aborted. All readies drop in the cycle after reset is sampled; nothing is replayed.
//  FSM has 2 states:
//   ARB:  no readies, m_axis_tvalid=0. One cycle is spent in ARB at every packet boundary.
//     - If credit!=0 and s_axis_tvalid[grant]: keep the grant, credit<=credit-1, go to XFER.
//     - Else pick the first requester scanning circularly from grant+1 (from port 0 after reset).
//       On a pick: grant<=pick, credit<=max(cfg_weight[pick],1)-1, go to XFER.
//     - If no tvalid is asserted: stay in ARB. grant and credit are held.
//   XFER: combinational pass-through of the granted port.
//     - m_axis_tdata, m_axis_tvalid and m_axis_tlast follow s_axis_*[grant].
//     - s_axis_tready[grant] = m_axis_tready; every other port sees tready=0.
//     - A beat transfers when m_axis_tvalid & m_axis_tready. Throughput is 1 beat per cycle.
//     - A handshake with tlast=1 returns the FSM to ARB on the next cycle.
//     - A tvalid gap inside a packet keeps the grant. No timeout; other ports wait.
//  m_axis_tid equals grant in XFER and holds its last value in ARB.
//  cfg_weight is sampled only when a new port is picked in ARB. Changes during XFER take effect at the next pick.
//  Latency: a request asserted while in ARB appears on m_axis in the following cycle. Zero-cycle data path during XFER.
//  Simultaneous requests are resolved by the circular scan. No port is starved: the worst-case wait is (N_PORTS-1) turns.
//  The circular scan wraps from N_PORTS-1 to 0.
//  credit is WEIGHT_W bits wide. A weight of 2^WEIGHT_W-1 is legal and must not overflow.
// STRUCTURE
//  Package axis_arb_pkg holds:
//   - typedef arb_state_e {ARB, XFER}
//   - localparam function clog2_min1 (returns at least 1 bit)
//   - typedefs port_idx_t and weight_t
//  Sub-module rr_pick (N_PORTS): combinational circular priority encoder.
//   - Inputs: req[N], start_idx. Outputs: found, idx.
//  The FSM, grant/credit registers and output mux live in the top module.
// TESTING
//  1 Reset: hold axis_areset 2 cycles with all tvalid=1.
//    -> s_axis_tready=0, m_axis_tvalid=0, m_axis_tid=0, busy=0 throughout.
//  2 Single packet: port0 sends 1..10, tlast on 10, m_axis_tready=1.
//    -> m_axis carries 1..10 in order, tid=0, tlast only on beat 10.
//    -> 1 ARB cycle before beat 1; 10 contiguous beats; busy is high for exactly those 10 cycles.
//  3 Fairness: weights {1,1}; both ports send back-to-back 3-beat packets.
//    -> the tid packet sequence is 0,1,0,1; each packet is separated by exactly one bubble.
//  4 Weighting: weights {3,1}, both ports always requesting.
//    -> the tid packet sequence is 0,0,0,1,0,0,0,1.
//    -> weight {0,1} gives 0,1,0,1 (a weight of 0 is treated as 1).
//  5 No interleave: port1 raises tvalid at beat 3 of a 10-beat port0 packet; m_axis_tready toggles 1,0,1,0.
//    -> all 10 port0 beats complete with none lost or duplicated; s_axis_tready[1]=0 until then.
//    -> port1's packet starts 1 ARB cycle after the port0 tlast handshake.
//  6 Reset mid-packet: assert axis_areset at beat 5 of a port1 packet.
//    -> all readies are 0 on the next edge.
//    -> after release, a port0 request wins first (pointer=0) with tid=0.

Source files
------------

// File: rtl/axis_wrr_pkt_arbiter_pkg.sv
// Shared types and helpers for the packet-level WRR stream arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_N_PORTS  = 2;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_WEIGHT_W = 4;

  typedef logic [clog2_min1(DEF_N_PORTS)-1:0] port_idx_t;
  typedef logic [DEF_WEIGHT_W-1:0]            weight_t;

endpackage

// File: rtl/axis_wrr_pkt_arbiter_if.sv
// Stream bundle around the arbiter: N slave inputs merged onto one master output.
// slave modport is the arbiter's view, master modport is the traffic side.
interface axis_wrr_pkt_arbiter_if
  import axis_arb_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W  = DEF_DATA_W
);
  localparam int IDX_W = clog2_min1(N_PORTS);

  logic [N_PORTS*DATA_W-1:0] s_axis_tdata;
  logic [N_PORTS-1:0]        s_axis_tvalid;
  logic [N_PORTS-1:0]        s_axis_tready;
  logic [N_PORTS-1:0]        s_axis_tlast;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic                      m_axis_tlast;
  logic [IDX_W-1:0]          m_axis_tid;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

endinterface

// File: rtl/axis_wrr_pkt_arbiter_rr_pick.sv
// Circular priority encoder: first set req bit at or after start_idx, wrapping.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int IDX_W   = clog2_min1(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   start_idx,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // Scan offsets 0..N-1 from start_idx; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      int j;
      j = int'(start_idx) + i;
      if (j >= N_PORTS) j = j - N_PORTS;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axis_wrr_pkt_arbiter.sv
// Packet-level weighted round-robin arbiter. A grant lasts from first beat to
// tlast; each grant turn carries a packet budget taken from cfg_weight.
module axis_wrr_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_PORTS  = DEF_N_PORTS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                        axis_aclk,
  input  logic                        axis_areset,
  axis_wrr_pkt_arbiter_if.slave       axis,
  input  logic [N_PORTS*WEIGHT_W-1:0] cfg_weight,
  output logic                        busy
);

  localparam int IDX_W = clog2_min1(N_PORTS);

  arb_state_e                         state, state_nx;
  logic [IDX_W-1:0]                   grant, grant_nx, start_idx, pick_idx;
  logic [WEIGHT_W-1:0]                credit, credit_nx, pick_w;
  logic                               picked, picked_nx;
  logic                               pick_found;
  logic [N_PORTS-1:0][DATA_W-1:0]     s_data;
  logic [N_PORTS-1:0][WEIGHT_W-1:0]   cfg_w;
  logic [N_PORTS-1:0]                 s_tready;
  logic                               m_tvalid;

  assign s_data = axis.s_axis_tdata;
  assign cfg_w  = cfg_weight;

  // Until the first pick after reset the scan starts at port 0; afterwards
  // it starts just past the current grant so the turn rotates.
  assign start_idx = !picked                        ? '0 :
                     (grant == IDX_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;

  rr_pick #(.N_PORTS(N_PORTS), .IDX_W(IDX_W)) u_pick (
    .req       (axis.s_axis_tvalid),
    .start_idx (start_idx),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  assign pick_w = cfg_w[pick_idx];

  // Next-state, grant/credit update and the pass-through handshake.
  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    credit_nx = credit;
    picked_nx = picked;
    m_tvalid  = 1'b0;
    s_tready  = '0;
    case (state)
      ARB: begin
        if (credit != '0 && axis.s_axis_tvalid[grant]) begin
          credit_nx = credit - 1'b1;
          state_nx  = XFER;
        end else if (pick_found) begin
          grant_nx  = pick_idx;
          // Weight 0 behaves as 1; 2^W-1 leaves 2^W-2, so no overflow.
          credit_nx = (pick_w == '0) ? '0 : pick_w - 1'b1;
          picked_nx = 1'b1;
          state_nx  = XFER;
        end
      end
      XFER: begin
        m_tvalid        = axis.s_axis_tvalid[grant];
        s_tready[grant] = axis.m_axis_tready;
        if (m_tvalid && axis.m_axis_tready && axis.s_axis_tlast[grant])
          state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
  end

  // State, grant and credit registers; reset aborts any packet in flight.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state  <= ARB;
      grant  <= '0;
      credit <= '0;
      picked <= 1'b0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      credit <= credit_nx;
      picked <= picked_nx;
    end
  end

  assign axis.s_axis_tready = s_tready;
  assign axis.m_axis_tvalid = m_tvalid;
  assign axis.m_axis_tdata  = s_data[grant];
  assign axis.m_axis_tlast  = (state == XFER) && axis.s_axis_tlast[grant];
  assign axis.m_axis_tid    = grant;
  assign busy               = (state == XFER);

endmodule

// File: tb/tb_axis_wrr_pkt_arbiter.sv
// Directed bench for the WRR packet arbiter with a beat scoreboard.
module tb_axis_wrr_pkt_arbiter;
  import axis_arb_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int WW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            tid;
  } beat_t;

  typedef struct {
    int   cyc;
    logic last;
    int   tid;
  } hs_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*WW-1:0] cfg_weight = '0;
  logic            busy;

  beat_t src_q0[$], src_q1[$], exp_q[$];
  hs_t   hs_log[$];
  int    cyc = 0, busy_cnt = 0, n_cmp = 0, n_err = 0;
  bit    hs0, hs1, tmode;

  axis_wrr_pkt_arbiter_if #(.N_PORTS(N), .DATA_W(DW)) bus ();

  axis_wrr_pkt_arbiter #(.N_PORTS(N), .DATA_W(DW), .WEIGHT_W(WW)) dut (
    .axis_aclk   (clk),
    .axis_areset (rst),
    .axis        (bus.slave),
    .cfg_weight  (cfg_weight),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dval(input int p, input int tag, input int b);
    return DW'((p << 16) | (tag << 8) | b);
  endfunction

  task automatic drive_srcs();
    logic [N*DW-1:0] d;
    logic [N-1:0]    v, l;
    d = '0; v = '0; l = '0;
    if (src_q0.size() > 0) begin
      v[0] = 1'b1; d[0 +: DW] = src_q0[0].data; l[0] = src_q0[0].last;
    end
    if (src_q1.size() > 0) begin
      v[1] = 1'b1; d[DW +: DW] = src_q1[0].data; l[1] = src_q1[0].last;
    end
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = v;
    bus.s_axis_tlast  = l;
  endtask

  task automatic load_pkt(input int p, input int len, input int tag);
    for (int b = 1; b <= len; b++) begin
      beat_t x;
      x.data = dval(p, tag, b); x.last = (b == len); x.tid = p;
      if (p == 0) src_q0.push_back(x); else src_q1.push_back(x);
    end
  endtask

  task automatic expect_pkt(input int p, input int len, input int tag);
    for (int b = 1; b <= len; b++) begin
      beat_t x;
      x.data = dval(p, tag, b); x.last = (b == len); x.tid = p;
      exp_q.push_back(x);
    end
  endtask

  // Source/sink driver: retire handshaken beats, then present queue heads.
  // A second pass after the directed block's edits makes loads visible the same cycle.
  always begin
    @(posedge clk); #1;
    if (hs0 && src_q0.size() > 0) void'(src_q0.pop_front());
    if (hs1 && src_q1.size() > 0) void'(src_q1.pop_front());
    bus.m_axis_tready = tmode ? cyc[0] : 1'b1;
    drive_srcs();
    #2;
    drive_srcs();
  end

  // Monitor on the falling edge: these values hold through the next rising edge.
  always @(negedge clk) begin
    hs_t   h;
    beat_t e;
    hs0 = bus.s_axis_tvalid[0] & bus.s_axis_tready[0];
    hs1 = bus.s_axis_tvalid[1] & bus.s_axis_tready[1];
    if (busy === 1'b1) busy_cnt++;
    if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
      h.cyc = cyc; h.last = bus.m_axis_tlast; h.tid = int'(bus.m_axis_tid);
      hs_log.push_back(h);
      if (exp_q.size() == 0) chk("sb_unexpected_beat", 64'(bus.m_axis_tdata), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_data", 64'(bus.m_axis_tdata), 64'(e.data));
        chk("sb_tid",  64'(bus.m_axis_tid),   64'(e.tid));
        chk("sb_last", 64'(bus.m_axis_tlast), 64'(e.last));
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic set_w(input int w0, input int w1);
    cfg_weight = {WW'(w1), WW'(w0)};
  endtask

  task automatic flush();
    src_q0.delete(); src_q1.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); flush(); rst = 1'b0;
  endtask

  task automatic wait_hs(input int n, input int budget, input string tag);
    int k = 0;
    while (hs_log.size() < n && k < budget) begin step(); k++; end
    chk(tag, 64'(hs_log.size() >= n), 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin step(); k++; end
    chk(tag, 64'(exp_q.size()), 64'd0);
    step(); step();
  endtask

  initial begin
    int base, k, tl;
    tmode = 1'b0;
    bus.m_axis_tready = 1'b1;

    // 1: reset held two cycles with every source requesting
    set_w(1, 1);
    load_pkt(0, 1, 1); load_pkt(1, 1, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
      chk("rst_mvalid", 64'(bus.m_axis_tvalid), 64'd0);
      chk("rst_tid",    64'(bus.m_axis_tid),    64'd0);
      chk("rst_busy",   64'(busy),              64'd0);
    end
    flush(); rst = 1'b0; step(); step();

    // 2: single 10-beat packet from port 0
    do_reset(); set_w(1, 1);
    base = hs_log.size(); k = cyc; busy_cnt = 0;
    load_pkt(0, 10, 2); expect_pkt(0, 10, 2);
    wait_idle(60, "t2_drain");
    chk("t2_beats",     64'(hs_log.size() - base),  64'd10);
    chk("t2_first_cyc", 64'(hs_log[base].cyc),      64'(k + 1));
    chk("t2_last_cyc",  64'(hs_log[base + 9].cyc),  64'(k + 10));
    chk("t2_busy_cnt",  64'(busy_cnt),              64'd10);

    // 3: equal weights, back-to-back 3-beat packets from both ports
    do_reset(); set_w(1, 1);
    base = hs_log.size();
    load_pkt(0, 3, 0); load_pkt(0, 3, 1); load_pkt(1, 3, 0); load_pkt(1, 3, 1);
    expect_pkt(0, 3, 0); expect_pkt(1, 3, 0); expect_pkt(0, 3, 1); expect_pkt(1, 3, 1);
    wait_idle(80, "t3_drain");
    for (int j = 1; j < 12; j++)
      chk($sformatf("t3_gap%0d", j), 64'(hs_log[base + j].cyc - hs_log[base + j - 1].cyc),
          64'((j % 3 == 0) ? 2 : 1));

    // 4: weights {3,1} then {0,1}
    do_reset(); set_w(3, 1);
    for (int t = 0; t < 6; t++) load_pkt(0, 2, t);
    load_pkt(1, 2, 0); load_pkt(1, 2, 1);
    for (int t = 0; t < 3; t++) expect_pkt(0, 2, t);
    expect_pkt(1, 2, 0);
    for (int t = 3; t < 6; t++) expect_pkt(0, 2, t);
    expect_pkt(1, 2, 1);
    wait_idle(100, "t4a_drain");

    do_reset(); set_w(0, 1);
    load_pkt(0, 2, 0); load_pkt(0, 2, 1); load_pkt(1, 2, 0); load_pkt(1, 2, 1);
    expect_pkt(0, 2, 0); expect_pkt(1, 2, 0); expect_pkt(0, 2, 1); expect_pkt(1, 2, 1);
    wait_idle(80, "t4b_drain");

    // 5: port 1 arrives mid-packet while m_axis_tready toggles
    do_reset(); set_w(1, 1); tmode = 1'b1;
    base = hs_log.size();
    load_pkt(0, 10, 4); expect_pkt(0, 10, 4);
    wait_hs(base + 2, 40, "t5_start");
    load_pkt(1, 4, 5); expect_pkt(1, 4, 5);
    tl = -1; k = 0;
    while (tl < 0 && k < 100) begin
      chk("t5_p1_blocked", 64'(bus.s_axis_tready[1]), 64'd0);
      step(); k++;
      if (hs_log.size() > base && hs_log[$].last && hs_log[$].tid == 0) tl = hs_log[$].cyc;
    end
    chk("t5_p0_tlast_seen", 64'(tl >= 0), 64'd1);
    chk("t5_arb_busy",   64'(busy),              64'd0);
    chk("t5_arb_mvalid", 64'(bus.m_axis_tvalid), 64'd0);
    step();
    chk("t5_p1_mvalid", 64'(bus.m_axis_tvalid), 64'd1);
    chk("t5_p1_tid",    64'(bus.m_axis_tid),    64'd1);
    wait_idle(100, "t5_drain");
    chk("t5_beats", 64'(hs_log.size() - base), 64'd14);
    tmode = 1'b0;

    // 6: reset in the middle of a port 1 packet
    do_reset(); set_w(1, 1);
    base = hs_log.size();
    load_pkt(1, 10, 6); expect_pkt(1, 10, 6);
    wait_hs(base + 4, 40, "t6_start");
    rst = 1'b1;
    step();
    chk("t6_rst_tready", 64'(bus.s_axis_tready), 64'd0);
    chk("t6_rst_mvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("t6_rst_busy",   64'(busy),              64'd0);
    flush();
    load_pkt(0, 3, 7); load_pkt(1, 3, 8);
    expect_pkt(0, 3, 7); expect_pkt(1, 3, 8);
    rst = 1'b0;
    wait_idle(60, "t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
